// File: rtl/unified_mem_responder.sv
// Word-addressed single-port memory with a power-on clear sequencer, a two-stage
// read path (rreg -> dout under oce) and sticky access-error flags.
module unified_mem_responder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        oce,
  input  logic        wre,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        rd_valid,
  output logic        busy,
  output logic [2:0]  err,
  input  logic        err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [31:0]       rreg_q, rreg_d;
  logic              pend_q, pend_d;
  logic [31:0]       dout_q, dout_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic [2:0]        err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we_s;
  logic [AW-1:0]     mem_waddr_s;
  logic [31:0]       mem_wdata_s;

  logic [AW-1:0]     idx_s;
  logic              misalign_s;
  logic              oor_s;

  assign idx_s      = addr[AW+1:2];
  assign misalign_s = |addr[1:0];
  // Any address bit above the word index means the access falls outside the array.
  assign oor_s      = |addr[31:AW+2];

  // Next-state, datapath and error-flag logic.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rreg_d      = rreg_q;
    pend_d      = pend_q;
    dout_d      = dout_q;
    rd_valid_d  = 1'b0;
    err_d       = err_clr ? 3'b000 : err_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = ptr_q;
    mem_wdata_s = 32'h0000_0000;

    case (state_q)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_waddr_s = ptr_q;
        mem_wdata_s = 32'h0000_0000;
        ptr_d       = ptr_q + 1'b1;
        err_d[2]    = err_d[2] | ce;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_READY: begin
        // Transfer happens before capture so a read+oce cycle pipelines cleanly.
        if (oce && pend_q) begin
          dout_d     = rreg_q;
          rd_valid_d = 1'b1;
          pend_d     = 1'b0;
        end else begin
          dout_d     = dout_q;
          rd_valid_d = 1'b0;
        end
        if (ce) begin
          err_d[1] = err_d[1] | misalign_s;
          err_d[0] = err_d[0] | oor_s;
          if (wre) begin
            mem_we_s    = ~oor_s;
            mem_waddr_s = idx_s;
            mem_wdata_s = din;
          end else begin
            rreg_d = oor_s ? 32'h0000_0000 : mem_q[idx_s];
            pend_d = 1'b1;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
        ptr_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_INIT);
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      rreg_q     <= 32'h0000_0000;
      pend_q     <= 1'b0;
      dout_q     <= 32'h0000_0000;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
      err_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rreg_q     <= rreg_d;
      pend_q     <= pend_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Storage array; contents are established by the clear sequencer, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed, table-driven bench for unified_mem_responder (DEPTH = 16).
module tb_unified_mem_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ce = 1'b0, oce = 1'b0, wre = 1'b0, err_clr = 1'b0;
  logic [31:0] addr = 32'h0, din = 32'h0;
  logic [31:0] dout;
  logic        rd_valid, busy;
  logic [2:0]  err;

  int n_checks = 0;
  int n_fail   = 0;

  unified_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .oce(oce), .wre(wre), .addr(addr),
    .din(din), .dout(dout), .rd_valid(rd_valid), .busy(busy), .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce, oce, wre, clr;
    logic [31:0] addr, din;
    logic [31:0] exp_dout;
    logic        exp_rv;
    logic [2:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic o, input logic w, input logic cl,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] ed, input logic erv, input logic [2:0] ee);
    vec_t v;
    v.ce = c; v.oce = o; v.wre = w; v.clr = cl; v.addr = a; v.din = d;
    v.exp_dout = ed; v.exp_rv = erv; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic o, input logic w, input logic cl,
                       input logic [31:0] a, input logic [31:0] d);
    ce = c; oce = o; wre = w; err_clr = cl; addr = a; din = d;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (busy === 1'b1 && n < 4 * DEPTH) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_dout", dout, 32'h0);
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h1 & 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h1);
    check("rst_err", {29'h0, err}, 32'h0);
    step();
    rst_n = 1'b1;

    // Write attempt during clear: ignored, flags busy_access
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'h1234_5678);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("init_busy_err", {29'h0, err}, 32'h4);
    check("init_busy_hi", {31'h0, busy}, 32'h1);
    wait_init(n);
    check("init_cycles", n + 1, DEPTH);
    check("init_busy_lo", {31'h0, busy}, 32'h0);

    // Word written during clear must read back 0; err stays sticky
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0);
    step();
    check("busy_wr_err_sticky", {29'h0, err}, 32'h4);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("busy_wr_dout", dout, 32'h0);
    check("busy_wr_rv", {31'h0, rd_valid}, 32'h1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h3C, 32'h0);
    step();
    check("errclr_err", {29'h0, err}, 32'h0);
    check("last_word_rv", {31'h0, rd_valid}, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("last_word_dout", dout, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();

    //              ce    oce   wre   clr   addr      din            dout           rv    err
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0,         32'h0,         1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b1, 3'b000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         32'hDEAD_BEEF, 1'b0, 3'b000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'hDEAD_BEEF, 1'b1, 3'b000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'hDEAD_BEEF, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h4,  32'h2222_2222, 32'hDEAD_BEEF, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'hDEAD_BEEF, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h4,  32'h0,         32'h1111_1111, 1'b1, 3'b000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'h2222_2222, 1'b1, 3'b000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         32'h2222_2222, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         32'h2222_2222, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  32'h3333_3333, 32'h2222_2222, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'h1111_1111, 1'b1, 3'b000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'h3333_3333, 1'b1, 3'b000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,         32'h3333_3333, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h6,  32'h0,         32'h3333_3333, 1'b0, 3'b010));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,         32'h2222_2222, 1'b1, 3'b000));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'hCAFE_F00D, 32'h2222_2222, 1'b0, 3'b001));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0,         32'h2222_2222, 1'b0, 3'b001));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h0,         32'h0,         1'b1, 3'b000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'h0,         1'b0, 3'b000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'h3333_3333, 1'b1, 3'b000));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  32'hFFFF_FFFF, 32'h3333_3333, 1'b0, 3'b000));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'h3333_3333, 1'b0, 3'b000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         32'h3333_3333, 1'b1, 3'b000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ce, vecs[i].oce, vecs[i].wre, vecs[i].clr, vecs[i].addr, vecs[i].din);
      step();
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      check($sformatf("vec%0d_rv", i), {31'h0, rd_valid}, {31'h0, vecs[i].exp_rv});
      check($sformatf("vec%0d_err", i), {29'h0, err}, {29'h0, vecs[i].exp_err});
      check($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
    end

    // Reset asserted with a read pending and rd_valid high
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    step();
    step();
    check("pre_rst_dout", dout, 32'hDEAD_BEEF);
    check("pre_rst_rv", {31'h0, rd_valid}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("midrd_rst_dout", dout, 32'h0);
    check("midrd_rst_rv", {31'h0, rd_valid}, 32'h0);
    check("midrd_rst_busy", {31'h0, busy}, 32'h1);
    step();
    rst_n = 1'b1;
    wait_init(n);
    check("reinit_cycles", n, DEPTH);

    // Clear restarts from word 0 when reset hits mid-clear
    step(); step();
    rst_n = 1'b0;
    #1;
    check("midinit_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b1;
    step(); step(); step(); step(); step();
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    wait_init(n);
    check("midinit_restart_cycles", n, DEPTH);

    // Memory cleared again: word 4 no longer holds DEADBEEF
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("recleared_dout", dout, 32'h0);
    check("recleared_rv", {31'h0, rd_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
